// File: rtl/pipe_mux_pkg.sv
// Shared types and constants for the pipe_sel_mux block.
//   occ_e      : skid buffer occupancy (EMPTY, ONE, TWO)
//   ERR_CNT_W  : width of the optional out-of-range select counter
//   sel_width  : minimum select width able to address n channels
package pipe_mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  localparam int ERR_CNT_W = 16;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pipe_mux_skid.sv
// Generic 2-entry skid buffer with valid/ready on both sides.
// The output always comes from main_q; skid_q only holds the beat that
// arrived while main_q was stalled. in_ready is registered, so there is no
// combinational path from out_ready back to in_ready.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   upstream handshake, in_data payload
//   out_valid/out_ready downstream handshake, out_data payload
module pipe_mux_skid
  import pipe_mux_pkg::*;
#(
  parameter int DW = 36
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  occ_e          state, state_nxt;
  logic [DW-1:0] main_q, skid_q;
  logic          ready_q;
  logic          acc, xfer;
  logic          ld_main_in, ld_main_skid, ld_skid;

  assign acc       = in_valid & ready_q;
  assign out_valid = (state != EMPTY);
  assign xfer      = out_valid & out_ready;
  assign in_ready  = ready_q;
  assign out_data  = main_q;

  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state)
      EMPTY: if (acc) begin
        ld_main_in = 1'b1;
        state_nxt  = ONE;
      end
      ONE: begin
        if (acc && xfer) begin
          ld_main_in = 1'b1;           // pass-through at full rate
        end else if (acc) begin
          ld_skid   = 1'b1;            // main stalled: park beat in skid
          state_nxt = TWO;
        end else if (xfer) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (xfer) begin
        ld_main_skid = 1'b1;
        state_nxt    = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != TWO);
      if (ld_main_in)        main_q <= in_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/pipe_sel_mux.sv
// N-way, W-bit registered select mux with valid/ready and 2-entry skid.
// Out-of-range selects (in_sel >= N) produce word 0 with out_err=1; the
// beat is still passed through in order.
// Optional build macro MUX_ERR_CNT_EN adds err_cnt, a saturating count of
// accepted out-of-range beats.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid, in_ready, in_sel,      upstream beat; channel k is
//   in_data                          in_data[k*W +: W]
//   out_valid, out_ready, out_data,  registered result, select echo and
//   out_sel, out_err                 range-error flag
//   err_cnt (MUX_ERR_CNT_EN only)    out-of-range beat counter
module pipe_sel_mux
  import pipe_mux_pkg::*;
#(
  parameter int N     = 5,
  parameter int W     = 32,
  parameter int SEL_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic [N*W-1:0]     in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_err
`ifdef MUX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int DW = SEL_W + 1 + W;

  if (SEL_W < sel_width(N)) begin : g_bad_cfg
    $error("pipe_sel_mux: SEL_W too narrow for N");
  end

  logic [N-1:0][W-1:0] ch;
  logic [W-1:0]        word;
  logic                sel_err;
  logic [DW-1:0]       skid_out;

  assign ch = in_data;

  // Match each channel index; nothing matching means out of range.
  always_comb begin
    word    = '0;
    sel_err = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) begin
        word    = ch[k];
        sel_err = 1'b0;
      end
    end
  end

  pipe_mux_skid #(.DW(DW)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_sel, sel_err, word}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (skid_out)
  );

  assign {out_sel, out_err, out_data} = skid_out;

`ifdef MUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (in_valid && in_ready && sel_err && (err_cnt != '1))
      err_cnt <= err_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Bench for pipe_sel_mux (N=5, W=32, SEL_W=3). Directed steps followed by
// randomized valid/ready traffic, all checked against a queue-based model
// of a 2-deep FIFO with registered ready.
module tb_pipe_sel_mux;
  localparam int N = 5, W = 32, SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [N*W-1:0]   in_data;
  logic             out_valid, out_ready;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_err;
`ifdef MUX_ERR_CNT_EN
  logic [15:0]      err_cnt;
`endif

  always #5 clk = ~clk;

  pipe_sel_mux #(.N(N), .W(W), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_err(out_err)
`ifdef MUX_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    logic [W-1:0]     data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_t;

  beat_t       q[$];
  int unsigned err_model = 0;
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t ref_beat();
    beat_t b;
    b.sel = in_sel;
    if (int'(in_sel) < N) begin
      b.data = in_data[int'(in_sel)*W +: W];
      b.err  = 1'b0;
    end else begin
      b.data = '0;
      b.err  = 1'b1;
    end
    return b;
  endfunction

  task automatic check_model();
    chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("m_out_data", 64'(out_data), 64'(q[0].data));
      chk("m_out_sel", 64'(out_sel), 64'(q[0].sel));
      chk("m_out_err", 64'(out_err), 64'(q[0].err));
    end
`ifdef MUX_ERR_CNT_EN
    chk("m_err_cnt", 64'(err_cnt), 64'(err_model));
`endif
  endtask

  // One clock: model decides accept/transfer from its own occupancy.
  task automatic cycle();
    bit    acc, xfer;
    beat_t b;
    acc  = in_valid && (q.size() < 2);
    xfer = (q.size() > 0) && out_ready;
    b    = ref_beat();
    @(posedge clk);
    if (xfer) q.delete(0);
    if (acc) begin
      q.push_back(b);
      if (b.err && err_model != 32'hFFFF) err_model++;
    end
    #1;
    check_model();
  endtask

  task automatic set_channels();
    for (int k = 0; k < N; k++) in_data[k*W +: W] = 32'h1000_0000 + 32'(k);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  accepted, cyc;
    bit  hold;
    in_valid  = 1'b0;
    in_sel    = '0;
    out_ready = 1'b1;
    set_channels();
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_sel", 64'(out_sel), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    check_model();

    // single beat, latency 1
    in_valid = 1'b1; in_sel = 3'd3;
    cycle();
    in_valid = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", 64'(out_data), 64'h1000_0003);
    chk("t1_err", 64'(out_err), 64'd0);
    cycle();
    chk("t1_empty", 64'(out_valid), 64'd0);

    // back-to-back stream
    for (int s = 0; s < N; s++) begin
      in_valid = 1'b1; in_sel = SEL_W'(s);
      cycle();
      chk("t2_data", 64'(out_data), 64'h1000_0000 + 64'(s));
      chk("t2_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    cycle();

    // stall: fill both entries, then drain
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 3'd1; cycle();
    in_sel = 3'd2; cycle();
    chk("t3_ready_low", 64'(in_ready), 64'd0);
    chk("t3_hold", 64'(out_data), 64'h1000_0001);
    in_sel = 3'd4; cycle();          // offered while full: ignored
    chk("t3_hold2", 64'(out_data), 64'h1000_0001);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("t3_second", 64'(out_data), 64'h1000_0002);
    chk("t3_ready_back", 64'(in_ready), 64'd1);
    cycle();
    chk("t3_drained", 64'(out_valid), 64'd0);

    // out-of-range selects
    in_valid = 1'b1; in_sel = 3'd6; cycle();
    chk("t4_data6", 64'(out_data), 64'd0);
    chk("t4_err6", 64'(out_err), 64'd1);
    chk("t4_sel6", 64'(out_sel), 64'd6);
    in_sel = 3'd7; cycle();
    chk("t4_err7", 64'(out_err), 64'd1);
    chk("t4_sel7", 64'(out_sel), 64'd7);
`ifdef MUX_ERR_CNT_EN
    chk("t4_err_cnt", 64'(err_cnt), 64'd2);
`endif
    in_valid = 1'b0; cycle();

    // async reset while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 3'd0; cycle();
    in_sel = 3'd1; cycle();
    chk("t5_full", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_ready", 64'(in_ready), 64'd1);
    chk("t5_async_data", 64'(out_data), 64'd0);
    chk("t5_async_err", 64'(out_err), 64'd0);
    q.delete();
    err_model = 0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("t5_no_stale", 64'(out_valid), 64'd0);

    // random traffic; a refused beat is held unchanged by upstream
    accepted = 0; cyc = 0; hold = 1'b0;
    while (accepted < 10000 && cyc < 60000) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 99) < 70);
        in_sel   = SEL_W'($urandom_range(0, 7));
        for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom;
      end
      out_ready = ($urandom_range(0, 99) < 70);
      hold = in_valid && !(q.size() < 2);
      if (in_valid && q.size() < 2) accepted++;
      cycle();
      cyc++;
    end
    chk("rnd_budget", 64'(accepted), 64'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    chk("rnd_drained", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
